// File: rtl/cpu_mulx_sequencer_if.sv
// Request/response and multiply-cell bundle for the multiply sequencer.
// The master side is the execute stage together with the multiply cell;
// the slave side is the sequencer itself.
interface cpu_mulx_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic [31:0] cell_result;

  modport master (
    output start, op, src1, src2, cell_result,
    input  busy, done, result, cell_src1, cell_src2
  );

  modport slave (
    input  start, op, src1, src2, cell_result,
    output busy, done, result, cell_src1, cell_src2
  );
endinterface

// File: rtl/cpu_mulx_sequencer.sv
// Multi-cycle multiply sequencer in front of a 32x32 low-product cell.
// MUL goes through the cell once; MULX* issues four zero-extended 16x16
// partial products, accumulates them into a 64-bit sum and corrects the
// high word for signed operands.
module cpu_mulx_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input logic                 clk,
  input logic                 reset,
  cpu_mulx_sequencer_if.slave bus
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [1:0]                   op_held;
  logic [31:0]                  a;
  logic [31:0]                  b;
  logic [1:0]                   k;
  logic [1:0]                   k_next;
  logic [63:0]                  acc;
  logic [CELL_LATENCY-1:0]      tag_valid;
  logic [CELL_LATENCY-1:0][1:0] tag_idx;
  logic                         busy;
  logic                         busy_next;
  logic                         done;
  logic                         done_next;
  logic [31:0]                  result;
  logic [31:0]                  result_next;
  logic [31:0]                  cell_src1;
  logic [31:0]                  cell_src1_next;
  logic [31:0]                  cell_src2;
  logic [31:0]                  cell_src2_next;
  logic                         accept;
  logic                         issue;
  logic                         capture;

  // Zero-extended 16-bit half of a word, upper or lower.
  function automatic logic [31:0] half_of(input logic [31:0] word, input logic upper);
    logic [31:0] h;
    if (upper) begin
      h = {16'd0, word[31:16]};
    end else begin
      h = {16'd0, word[15:0]};
    end
    return h;
  endfunction

  // Partial product placed at its weight for issue index idx.
  function automatic logic [63:0] pp_weight(input logic [1:0] idx, input logic [31:0] pp);
    logic [63:0] w;
    case (idx)
      2'd0:       w = {32'd0, pp};
      2'd1, 2'd2: w = {16'd0, pp, 16'd0};
      2'd3:       w = {pp, 32'd0};
      default:    w = 64'd0;
    endcase
    return w;
  endfunction

  // Signed correction of the unsigned high word, all modulo 2^32.
  function automatic logic [31:0] fix_high(input logic [31:0] hi_in, input logic [31:0] opa,
                                           input logic [31:0] opb, input logic [1:0] opc);
    logic [31:0] hi;
    hi = hi_in;
    if (((opc == OP_MULXSU) || (opc == OP_MULXSS)) && opa[31]) begin
      hi = hi - opb;
    end else begin
      hi = hi;
    end
    if ((opc == OP_MULXSS) && opb[31]) begin
      hi = hi - opa;
    end else begin
      hi = hi;
    end
    return hi;
  endfunction

  assign issue   = (state == ST_ISSUE);
  assign capture = tag_valid[CELL_LATENCY-1];

  // Next-state, issue operands and output values for the sequencer FSM.
  always_comb begin
    state_next     = state;
    k_next         = k;
    accept         = 1'b0;
    busy_next      = busy;
    done_next      = 1'b0;
    result_next    = result;
    cell_src1_next = 32'd0;
    cell_src2_next = 32'd0;
    case (state)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (bus.start) begin
          accept     = 1'b1;
          busy_next  = 1'b1;
          k_next     = 2'd0;
          state_next = ST_ISSUE;
          if (bus.op == OP_MUL) begin
            cell_src1_next = bus.src1;
            cell_src2_next = bus.src2;
          end else begin
            cell_src1_next = half_of(bus.src1, 1'b0);
            cell_src2_next = half_of(bus.src2, 1'b0);
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((op_held == OP_MUL) || (k == 2'd3)) begin
          state_next = ST_DRAIN;
        end else begin
          k_next         = k + 2'd1;
          cell_src1_next = half_of(a, k_next[1]);
          cell_src2_next = half_of(b, k_next[0]);
        end
      end
      ST_DRAIN: begin
        // Leave only once every issued product has been folded into acc.
        if (tag_valid == {CELL_LATENCY{1'b0}}) begin
          if (op_held == OP_MUL) begin
            result_next = acc[31:0];
            done_next   = 1'b1;
            busy_next   = 1'b0;
            state_next  = ST_DONE;
          end else begin
            state_next = ST_FIX;
          end
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_FIX: begin
        result_next = fix_high(acc[63:32], a, b, op_held);
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and issue index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      k     <= 2'd0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  // Registered outputs toward the execute stage and the multiply cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      cell_src1 <= 32'd0;
      cell_src2 <= 32'd0;
    end else begin
      busy      <= busy_next;
      done      <= done_next;
      result    <= result_next;
      cell_src1 <= cell_src1_next;
      cell_src2 <= cell_src2_next;
    end
  end

  // Operand latch and 64-bit accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_held <= 2'b00;
      a       <= 32'd0;
      b       <= 32'd0;
      acc     <= 64'd0;
    end else if (accept) begin
      op_held <= bus.op;
      a       <= bus.src1;
      b       <= bus.src2;
      acc     <= 64'd0;
    end else if (capture) begin
      acc <= acc + pp_weight(tag_idx[CELL_LATENCY-1], bus.cell_result);
    end
  end

  // Tag pipeline: follows each issued index until the cell returns its product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= {CELL_LATENCY{1'b0}};
      tag_idx   <= {CELL_LATENCY{2'b00}};
    end else begin
      for (int i = CELL_LATENCY - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
      tag_valid[0] <= issue;
      tag_idx[0]   <= k;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.cell_src1 = cell_src1;
  assign bus.cell_src2 = cell_src2;

endmodule

// File: tb/tb_cpu_mulx_sequencer.sv
// Directed bench for cpu_mulx_sequencer: one DUT with a single-edge cell,
// one with a two-edge cell; each cell is a small pipelined multiplier model.
module tb_cpu_mulx_sequencer;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] tr_a [0:15];
  logic [31:0] tr_b [0:15];

  cpu_mulx_sequencer_if bus1 ();
  cpu_mulx_sequencer_if bus2 ();

  cpu_mulx_sequencer #(.CELL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  cpu_mulx_sequencer #(.CELL_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] c1_a, c1_b, c2_a0, c2_b0, c2_a1, c2_b1;

  // Single-edge cell: registered multipliers, combinational low product.
  always_ff @(posedge clk) begin
    c1_a <= bus1.cell_src1;
    c1_b <= bus1.cell_src2;
  end
  assign bus1.cell_result = c1_a * c1_b;

  // Two-edge cell: two operand register stages.
  always_ff @(posedge clk) begin
    c2_a0 <= bus2.cell_src1;
    c2_b0 <= bus2.cell_src2;
    c2_a1 <= c2_a0;
    c2_b1 <= c2_b0;
  end
  assign bus2.cell_result = c2_a1 * c2_b1;

  task automatic drive_in(input int sel, input logic st, input logic [1:0] op,
                          input logic [31:0] s1, input logic [31:0] s2);
    if (sel == 1) begin
      bus1.start = st; bus1.op = op; bus1.src1 = s1; bus1.src2 = s2;
    end else begin
      bus2.start = st; bus2.op = op; bus2.src1 = s1; bus2.src2 = s2;
    end
  endtask

  task automatic peek(input int sel, output logic bz, output logic dn, output logic [31:0] rs,
                      output logic [31:0] ca, output logic [31:0] cb);
    if (sel == 1) begin
      bz = bus1.busy; dn = bus1.done; rs = bus1.result; ca = bus1.cell_src1; cb = bus1.cell_src2;
    end else begin
      bz = bus2.busy; dn = bus2.done; rs = bus2.result; ca = bus2.cell_src1; cb = bus2.cell_src2;
    end
  endtask

  // Issue one request and follow it to done; lat counts edges from accept.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input bit poke, output int lat,
                        output int busy_cnt, output logic busy_at_done, output logic [31:0] res);
    logic bz, dn;
    logic [31:0] rs, ca, cb;
    repeat (2) @(negedge clk);
    drive_in(sel, 1'b1, op, s1, s2);
    @(posedge clk); #1;
    lat = 0; busy_cnt = 0;
    peek(sel, bz, dn, rs, ca, cb);
    tr_a[0] = ca; tr_b[0] = cb;
    if (bz && !dn) busy_cnt++;
    drive_in(sel, poke, ~op, ~s1, s2 + 32'd1);
    while (!dn && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) drive_in(sel, 1'b0, ~op, ~s1, s2 + 32'd1);
      peek(sel, bz, dn, rs, ca, cb);
      if (lat < 16) begin tr_a[lat] = ca; tr_b[lat] = cb; end
      if (bz && !dn) busy_cnt++;
    end
    busy_at_done = bz;
    res = rs;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_in(1, 1'b0, 2'b00, 32'd0, 32'd0);
    drive_in(2, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    n_vec++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus1.done); end
    n_vec++; if (bus1.result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", bus1.result); end
    n_vec++; if ({bus1.cell_src1, bus1.cell_src2} !== 64'd0) begin n_err++; $display("FAIL reset_cell_src got %h %h want 0", bus1.cell_src1, bus1.cell_src2); end
    n_vec++; if ({bus2.busy, bus2.done} !== 2'b00) begin n_err++; $display("FAIL reset_bus2 got %b want 00", {bus2.busy, bus2.done}); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc; logic bd; logic [31:0] res;
    run_op(1, 2'b00, 32'd7, 32'd6, 1'b0, lat, bc, bd, res);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL mul_latency got %0d want 3", lat); end
    n_vec++; if (res !== 32'h0000002A) begin n_err++; $display("FAIL mul_result got %h want 0000002a", res); end
    n_vec++; if (bc !== 3) begin n_err++; $display("FAIL mul_busy_cycles got %0d want 3", bc); end
    n_vec++; if (bd !== 1'b0) begin n_err++; $display("FAIL mul_busy_at_done got %b want 0", bd); end
    n_vec++; if ({tr_a[0], tr_b[0]} !== {32'd7, 32'd6}) begin n_err++; $display("FAIL mul_issue got %h %h want 7 6", tr_a[0], tr_b[0]); end
    n_vec++; if ({tr_a[1], tr_b[1]} !== 64'd0) begin n_err++; $display("FAIL mul_idle_operands got %h %h want 0 0", tr_a[1], tr_b[1]); end
    @(posedge clk); #1;
    n_vec++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse got %b want 0", bus1.done); end
    n_vec++; if (bus1.result !== 32'h0000002A) begin n_err++; $display("FAIL mul_result_hold got %h want 0000002a", bus1.result); end
  endtask

  task automatic test_mulx();
    int lat, bc; logic bd; logic [31:0] res;
    logic [1:0]  ops [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
    logic [31:0] s1s [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] s2s [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'h00000000, 32'h40000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(1, ops[i], s1s[i], s2s[i], 1'b0, lat, bc, bd, res);
      n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL mulx_result[%0d] got %h want %h", i, res, exp[i]); end
      n_vec++; if (lat !== 7) begin n_err++; $display("FAIL mulx_latency[%0d] got %0d want 7", i, lat); end
      if (i == 0) begin
        n_vec++; if (bc !== 7) begin n_err++; $display("FAIL mulx_busy_cycles got %0d want 7", bc); end
        for (int j = 0; j < 4; j++) begin
          n_vec++; if ({tr_a[j], tr_b[j]} !== {32'h0000FFFF, 32'h0000FFFF}) begin n_err++; $display("FAIL mulx_issue[%0d] got %h %h want 0000ffff 0000ffff", j, tr_a[j], tr_b[j]); end
        end
        n_vec++; if ({tr_a[4], tr_b[4]} !== 64'd0) begin n_err++; $display("FAIL mulx_idle_operands got %h %h want 0 0", tr_a[4], tr_b[4]); end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc; logic bd; logic [31:0] res;
    int extra;
    run_op(1, 2'b00, 32'd9, 32'd9, 1'b1, lat, bc, bd, res);
    n_vec++; if (res !== 32'h00000051) begin n_err++; $display("FAIL busy_start_result got %h want 00000051", res); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL busy_start_latency got %0d want 3", lat); end
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus1.busy || bus1.done) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL busy_start_ignored got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b00, 2'b11};
    logic [31:0] s1s [4] = '{32'd2, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] s2s [4] = '{32'd3, 32'h00010000, 32'd2, 32'd2};
    logic [31:0] exp [4] = '{32'h00000006, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int acc_n, done_n, last_done, cyc;
    logic prev_busy;
    acc_n = 0; done_n = 0; last_done = -100;
    repeat (2) @(negedge clk);
    drive_in(1, 1'b1, ops[0], s1s[0], s2s[0]);
    prev_busy = bus1.busy;
    for (cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk); #1;
      if (bus1.busy && !prev_busy) begin
        if (acc_n > 0) begin
          n_vec++; if (cyc !== last_done + 2) begin n_err++; $display("FAIL b2b_accept[%0d] got cycle %0d want %0d", acc_n, cyc, last_done + 2); end
        end
        acc_n++;
        if (acc_n < 4) drive_in(1, 1'b1, ops[acc_n], s1s[acc_n], s2s[acc_n]);
        else drive_in(1, 1'b0, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
      end
      if (bus1.done) begin
        if (done_n < 4) begin
          n_vec++; if (bus1.result !== exp[done_n]) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", done_n, bus1.result, exp[done_n]); end
        end
        done_n++;
        last_done = cyc;
      end
      prev_busy = bus1.busy;
      if (done_n >= 4 && cyc > last_done + 6) break;
    end
    n_vec++; if (acc_n !== 4) begin n_err++; $display("FAIL b2b_accepts got %0d want 4", acc_n); end
    n_vec++; if (done_n !== 4) begin n_err++; $display("FAIL b2b_dones got %0d want 4", done_n); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dn_cnt; logic bd; logic [31:0] res;
    repeat (2) @(negedge clk);
    drive_in(1, 1'b1, 2'b01, 32'h12345678, 32'h12345678);
    @(posedge clk); #1;
    drive_in(1, 1'b0, 2'b01, 32'h12345678, 32'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++; if ({bus1.busy, bus1.done} !== 2'b00) begin n_err++; $display("FAIL midreset_flags got %b want 00", {bus1.busy, bus1.done}); end
    n_vec++; if (bus1.result !== 32'd0) begin n_err++; $display("FAIL midreset_result got %h want 0", bus1.result); end
    n_vec++; if ({bus1.cell_src1, bus1.cell_src2} !== 64'd0) begin n_err++; $display("FAIL midreset_cell_src got %h %h want 0", bus1.cell_src1, bus1.cell_src2); end
    @(negedge clk);
    reset = 1'b0;
    dn_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus1.done || bus1.busy) dn_cnt++;
    end
    n_vec++; if (dn_cnt !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d active cycles want 0", dn_cnt); end
    run_op(1, 2'b00, 32'd3, 32'd5, 1'b0, lat, bc, bd, res);
    n_vec++; if (res !== 32'h0000000F) begin n_err++; $display("FAIL midreset_next_result got %h want 0000000f", res); end
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL midreset_next_latency got %0d want 3", lat); end
  endtask

  task automatic test_latency2();
    int lat, bc; logic bd; logic [31:0] res;
    logic [31:0] ea [5] = '{32'h00005678, 32'h00005678, 32'h00001234, 32'h00001234, 32'h0};
    logic [31:0] eb [5] = '{32'h0000DEF0, 32'h00009ABC, 32'h0000DEF0, 32'h00009ABC, 32'h0};
    run_op(2, 2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0, lat, bc, bd, res);
    n_vec++; if (res !== 32'h0B00EA4E) begin n_err++; $display("FAIL lat2_mulx_result got %h want 0b00ea4e", res); end
    n_vec++; if (lat !== 8) begin n_err++; $display("FAIL lat2_mulx_latency got %0d want 8", lat); end
    for (int j = 0; j < 5; j++) begin
      n_vec++; if ({tr_a[j], tr_b[j]} !== {ea[j], eb[j]}) begin n_err++; $display("FAIL lat2_issue[%0d] got %h %h want %h %h", j, tr_a[j], tr_b[j], ea[j], eb[j]); end
    end
    run_op(2, 2'b00, 32'd10, 32'd10, 1'b0, lat, bc, bd, res);
    n_vec++; if (res !== 32'h00000064) begin n_err++; $display("FAIL lat2_mul_result got %h want 00000064", res); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL lat2_mul_latency got %0d want 4", lat); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mul();
    test_mulx();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_latency2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
